cn_minsum: RTL

CN_MINSUM -- requirements
Module: cn_minsum

---
 rtl/cn_pkg.sv | 10 +
 rtl/cn_min_tracker.sv | 26 ++
 rtl/cn_minsum.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/cn_pkg.sv
// cn_pkg: shared widths, saturation limit and FSM encodings for the min-sum check node
package cn_pkg;
    localparam int LLR_W = 6;
    localparam int MAG_W = 5;
    localparam logic [MAG_W-1:0] MAG_MAX = 5'd31;
    localparam logic [0:0] C_COLLECT = 1'b0;
    localparam logic [0:0] C_HOLD = 1'b1;
    localparam logic [0:0] E_IDLE = 1'b0;
    localparam logic [0:0] E_EMIT = 1'b1;
endpackage

// File: rtl/cn_min_tracker.sv
// cn_min_tracker: one step of the running min1/min2/index/sign-parity update
module cn_min_tracker
    import cn_pkg::*;
#(
    parameter int IW = 4
) (
    input  logic [MAG_W-1:0] min1,
    input  logic [MAG_W-1:0] min2,
    input  logic [IW-1:0]    idx,
    input  logic             sgn,
    input  logic [MAG_W-1:0] mag,
    input  logic             vsgn,
    input  logic [IW-1:0]    e_idx,
    output logic [MAG_W-1:0] n_min1,
    output logic [MAG_W-1:0] n_min2,
    output logic [IW-1:0]    n_idx,
    output logic             n_sgn
);
    // strict compares so ties keep the earlier index
    always_comb begin
        n_min1 = (mag < min1) ? mag : min1;
        n_min2 = (mag < min1) ? min1 : ((mag < min2) ? mag : min2);
        n_idx  = (mag < min1) ? e_idx : idx;
        n_sgn  = sgn ^ vsgn;
    end
endmodule

// File: rtl/cn_minsum.sv
// cn_minsum: ping-pong min-sum check node; define CN_OFFSET_EN for offset min-sum
module cn_minsum
    import cn_pkg::*;
#(
    parameter int DC = 16,
    parameter int OFFSET = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [LLR_W-1:0] vin,
    input  logic             vin_en,
    output logic             in_ready,
    output logic [LLR_W-1:0] cout,
    output logic             cout_en,
    output logic             err_ovf
);
    localparam int CW = (DC > 1) ? $clog2(DC) : 1;
    localparam logic [CW-1:0] LAST = CW'(DC - 1);
    localparam logic [MAG_W-1:0] OFF = MAG_W'(OFFSET);
`ifdef CN_OFFSET_EN
    localparam bit OFF_EN = 1'b1;
`else
    localparam bit OFF_EN = 1'b0;
`endif

    logic [0:0] cst_q, cst_d, est_q, est_d;
    logic [CW-1:0] cnt_q, cnt_d, ecnt_q, ecnt_d;
    logic bank_q, bank_d, ebank_q, ebank_d;
    logic [MAG_W-1:0] min1_q, min1_d, min2_q, min2_d;
    logic [CW-1:0] idx_q, idx_d;
    logic sgn_q, sgn_d;
    logic smem_q [2][DC];
    logic smem_d [2][DC];
    logic [MAG_W-1:0] bmin1_q [2], bmin1_d [2], bmin2_q [2], bmin2_d [2];
    logic [CW-1:0] bidx_q [2], bidx_d [2];
    logic bsgn_q [2], bsgn_d [2];
    logic [LLR_W-1:0] cout_q, cout_d, vneg, val;
    logic err_q, err_d;
    logic [MAG_W-1:0] vmag, m, mo;
    logic [MAG_W-1:0] t_min1, t_min2;
    logic [CW-1:0] t_idx;
    logic t_sgn, s;
    logic accept, last, done, e_last, e_free, handover;

    assign in_ready = cst_q == C_COLLECT;
    assign accept   = vin_en && in_ready;
    assign last     = cnt_q == LAST;
    assign done     = accept && last;
    assign e_last   = ecnt_q == LAST;
    assign e_free   = (est_q == E_IDLE) || e_last;
    assign handover = (done || cst_q == C_HOLD) && e_free;
    assign err_ovf  = err_q;
    assign vneg     = -vin;
    assign vmag     = (vin == 6'b100000) ? MAG_MAX : (vin[5] ? vneg[4:0] : vin[4:0]);

    cn_min_tracker #(.IW(CW)) u_trk (
        .min1(min1_q), .min2(min2_q), .idx(idx_q), .sgn(sgn_q),
        .mag(vmag), .vsgn(vin[5]), .e_idx(cnt_q),
        .n_min1(t_min1), .n_min2(t_min2), .n_idx(t_idx), .n_sgn(t_sgn)
    );

    // collect side: accumulate a group into the write bank, publish its summary on the last beat
    always_comb begin
        cst_d = cst_q;
        cnt_d = cnt_q;
        bank_d = bank_q;
        min1_d = min1_q;
        min2_d = min2_q;
        idx_d = idx_q;
        sgn_d = sgn_q;
        smem_d = smem_q;
        bmin1_d = bmin1_q;
        bmin2_d = bmin2_q;
        bidx_d = bidx_q;
        bsgn_d = bsgn_q;
        err_d = err_q | (vin_en & ~in_ready);
        if (accept) begin
            smem_d[bank_q][cnt_q] = vin[5];
            cnt_d = last ? '0 : cnt_q + 1'b1;
            min1_d = last ? MAG_MAX : t_min1;
            min2_d = last ? MAG_MAX : t_min2;
            idx_d = last ? '0 : t_idx;
            sgn_d = last ? 1'b0 : t_sgn;
            if (last) begin
                bmin1_d[bank_q] = t_min1;
                bmin2_d[bank_q] = t_min2;
                bidx_d[bank_q] = t_idx;
                bsgn_d[bank_q] = t_sgn;
            end
        end
        if (handover) begin
            bank_d = ~bank_q;
            cst_d = C_COLLECT;
        end else if (done) begin
            cst_d = C_HOLD;
        end
    end

    // emit side: walk edges 0..DC-1 of the read bank, chaining straight into the next group
    always_comb begin
        est_d = est_q;
        ecnt_d = ecnt_q;
        ebank_d = ebank_q;
        if (est_q == E_EMIT) begin
            ecnt_d = e_last ? '0 : ecnt_q + 1'b1;
            est_d = e_last ? E_IDLE : E_EMIT;
        end
        if (handover) begin
            est_d = E_EMIT;
            ecnt_d = '0;
            ebank_d = bank_q;
        end
    end

    // output: min2 on the min1 edge, optional offset, then apply extrinsic sign; hold when idle
    always_comb begin
        m = (ecnt_q == bidx_q[ebank_q]) ? bmin2_q[ebank_q] : bmin1_q[ebank_q];
        mo = !OFF_EN ? m : ((m > OFF) ? m - OFF : '0);
        s = bsgn_q[ebank_q] ^ smem_q[ebank_q][ecnt_q];
        val = s ? -{1'b0, mo} : {1'b0, mo};
        cout_en = est_q == E_EMIT;
        cout = cout_en ? val : cout_q;
        cout_d = cout;
    end

    // state registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cst_q <= C_COLLECT;
            est_q <= E_IDLE;
            cnt_q <= '0;
            ecnt_q <= '0;
            bank_q <= 1'b0;
            ebank_q <= 1'b0;
            min1_q <= MAG_MAX;
            min2_q <= MAG_MAX;
            idx_q <= '0;
            sgn_q <= 1'b0;
            cout_q <= '0;
            err_q <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                bmin1_q[b] <= MAG_MAX;
                bmin2_q[b] <= MAG_MAX;
                bidx_q[b] <= '0;
                bsgn_q[b] <= 1'b0;
                for (int i = 0; i < DC; i++) smem_q[b][i] <= 1'b0;
            end
        end else begin
            cst_q <= cst_d;
            est_q <= est_d;
            cnt_q <= cnt_d;
            ecnt_q <= ecnt_d;
            bank_q <= bank_d;
            ebank_q <= ebank_d;
            min1_q <= min1_d;
            min2_q <= min2_d;
            idx_q <= idx_d;
            sgn_q <= sgn_d;
            cout_q <= cout_d;
            err_q <= err_d;
            bmin1_q <= bmin1_d;
            bmin2_q <= bmin2_d;
            bidx_q <= bidx_d;
            bsgn_q <= bsgn_d;
            smem_q <= smem_d;
        end
    end
endmodule
